// File: rtl/rns_cmp_arbiter_pkg.sv
// Shared definitions for the RNS comparator arbiter.
// Residue system: moduli {7, 8, 9}, dynamic range 0..503.
// Holds moduli/width constants, the packed residue triple, the result
// encoding {err, gr, eq, le}, and the CRT reconstruction helper.
package rns_cmp_arbiter_pkg;

    localparam int M1        = 7;
    localparam int M2        = 8;
    localparam int M3        = 9;
    localparam int RNS_RANGE = M1 * M2 * M3;   // 504

    localparam int R1W = 3;
    localparam int R2W = 3;
    localparam int R3W = 4;
    localparam int XW  = 9;                    // enough for 0..503

    typedef struct packed {
        logic [R3W-1:0] r3;
        logic [R2W-1:0] r2;
        logic [R1W-1:0] r1;
    } rns_t;

    typedef struct packed {
        logic err;
        logic gr;
        logic eq;
        logic le;
    } cmp_res_t;

    // CRT basis weights: each is 1 modulo its own modulus and 0 modulo the
    // other two (288 = 72*4, 441 = 63*7, 280 = 56*5). Worst-case weighted
    // sum is 7055, so 13 bits hold it before the final mod-504 fold.
    function automatic logic [XW-1:0] rns_crt(input rns_t r);
        logic [12:0] sum;
        sum = 13'(r.r1) * 13'd288 + 13'(r.r2) * 13'd441 + 13'(r.r3) * 13'd280;
        return XW'(sum % 13'(RNS_RANGE));
    endfunction

endpackage

// File: rtl/rns_cmp_arbiter_core.sv
// rns_cmp_core: combinational magnitude comparator for two RNS triples.
// Ports:
//   a_i, b_i : residue triples (mod 7, mod 8, mod 9)
//   le_o     : A < B
//   eq_o     : A == B
//   gr_o     : A > B
//   err_o    : a residue of either operand is out of range; flags forced 0
module rns_cmp_core
    import rns_cmp_arbiter_pkg::*;
(
    input  rns_t a_i,
    input  rns_t b_i,
    output logic le_o,
    output logic eq_o,
    output logic gr_o,
    output logic err_o
);

    logic [XW-1:0] xa;
    logic [XW-1:0] xb;

    assign xa = rns_crt(a_i);
    assign xb = rns_crt(b_i);

    // The mod-8 residue uses every 3-bit code, so only r1 and r3 can be illegal.
    assign err_o = (a_i.r1 > R1W'(M1 - 1)) || (a_i.r3 > R3W'(M3 - 1)) ||
                   (b_i.r1 > R1W'(M1 - 1)) || (b_i.r3 > R3W'(M3 - 1));

    assign le_o = !err_o && (xa <  xb);
    assign eq_o = !err_o && (xa == xb);
    assign gr_o = !err_o && (xa >  xb);

endmodule

// File: rtl/rns_cmp_arbiter.sv
// rns_cmp_arbiter: round-robin arbiter in front of a shared RNS comparator,
// followed by a 2-stage pipeline (S1 operand register, S2 result register).
// Ports:
//   clk_in, rst_n_in            : clock, async active-low reset
//   req_valid_in/req_ready_out  : per-requester handshake (ready is one-hot or 0)
//   req_{a,b}{1,2,3}_in         : packed per-requester residues
//   resp_valid_out/resp_ready_in: result handshake
//   resp_id_out                 : requester index of the result
//   resp_le/eq/gr/err_out       : comparison result
//   busy_out                    : either pipeline stage occupied
module rns_cmp_arbiter
    import rns_cmp_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [NREQ-1:0]   req_valid_in,
    output logic [NREQ-1:0]   req_ready_out,
    input  logic [3*NREQ-1:0] req_a1_in,
    input  logic [3*NREQ-1:0] req_a2_in,
    input  logic [4*NREQ-1:0] req_a3_in,
    input  logic [3*NREQ-1:0] req_b1_in,
    input  logic [3*NREQ-1:0] req_b2_in,
    input  logic [4*NREQ-1:0] req_b3_in,
    output logic              resp_valid_out,
    input  logic              resp_ready_in,
    output logic [IDW-1:0]    resp_id_out,
    output logic              resp_le_out,
    output logic              resp_eq_out,
    output logic              resp_gr_out,
    output logic              resp_err_out,
    output logic              busy_out
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_v_q, s1_v_d;
    rns_t           s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_v_q, s2_v_d;
    cmp_res_t       s2_res_q, s2_res_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;

    logic           s2_adv, s1_adv;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic           xfer;
    rns_t           sel_a, sel_b;
    cmp_res_t       core_res;
    int             idx;
    int             g;

    assign s2_adv = !s2_v_q || resp_ready_in;
    assign s1_adv = !s1_v_q || s2_adv;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid_in[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    assign xfer = gnt_found && s1_adv;

    // Ready is held low during reset so every output reads 0 while asserted.
    always_comb begin
        req_ready_out = '0;
        if (xfer && rst_n_in)
            req_ready_out[gnt_idx] = 1'b1;
    end

    always_comb begin
        g        = int'(gnt_idx);
        sel_a.r1 = req_a1_in[3*g +: 3];
        sel_a.r2 = req_a2_in[3*g +: 3];
        sel_a.r3 = req_a3_in[4*g +: 4];
        sel_b.r1 = req_b1_in[3*g +: 3];
        sel_b.r2 = req_b2_in[3*g +: 3];
        sel_b.r3 = req_b3_in[4*g +: 4];
    end

    rns_cmp_core u_core (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .le_o  (core_res.le),
        .eq_o  (core_res.eq),
        .gr_o  (core_res.gr),
        .err_o (core_res.err)
    );

    always_comb begin
        ptr_d    = ptr_q;
        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_id_d  = s1_id_q;
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
        s2_id_d  = s2_id_q;

        if (xfer) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end

        if (s1_adv) begin
            s1_v_d = xfer;
            if (xfer) begin
                s1_a_d  = sel_a;
                s1_b_d  = sel_b;
                s1_id_d = gnt_idx;
            end
        end

        // When S2 may advance it takes whatever S1 holds (possibly nothing).
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_res_d = core_res;
                s2_id_d  = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q    <= '0;
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_id_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_res_q <= '0;
            s2_id_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_v_q   <= s1_v_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_id_q  <= s1_id_d;
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_id_q  <= s2_id_d;
        end
    end

    assign resp_valid_out = s2_v_q;
    assign resp_id_out    = s2_id_q;
    assign resp_le_out    = s2_res_q.le;
    assign resp_eq_out    = s2_res_q.eq;
    assign resp_gr_out    = s2_res_q.gr;
    assign resp_err_out   = s2_res_q.err;
    assign busy_out       = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_rns_cmp_arbiter.sv
module tb_rns_cmp_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [NREQ-1:0]   req_valid_in;
    logic [NREQ-1:0]   req_ready_out;
    logic [3*NREQ-1:0] req_a1_in, req_a2_in, req_b1_in, req_b2_in;
    logic [4*NREQ-1:0] req_a3_in, req_b3_in;
    logic              resp_valid_out, resp_ready_in;
    logic [IDW-1:0]    resp_id_out;
    logic              resp_le_out, resp_eq_out, resp_gr_out, resp_err_out;
    logic              busy_out;

    rns_cmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_a1_in      (req_a1_in),
        .req_a2_in      (req_a2_in),
        .req_a3_in      (req_a3_in),
        .req_b1_in      (req_b1_in),
        .req_b2_in      (req_b2_in),
        .req_b3_in      (req_b3_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_id_out    (resp_id_out),
        .resp_le_out    (resp_le_out),
        .resp_eq_out    (resp_eq_out),
        .resp_gr_out    (resp_gr_out),
        .resp_err_out   (resp_err_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Per-requester raw residues, packed onto the DUT buses.
    int ta1[NREQ], ta2[NREQ], ta3[NREQ], tb1[NREQ], tb2[NREQ], tb3[NREQ];

    always_comb begin
        req_a1_in = '0; req_a2_in = '0; req_a3_in = '0;
        req_b1_in = '0; req_b2_in = '0; req_b3_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a1_in[3*i +: 3] = 3'(ta1[i]);
            req_a2_in[3*i +: 3] = 3'(ta2[i]);
            req_a3_in[4*i +: 4] = 4'(ta3[i]);
            req_b1_in[3*i +: 3] = 3'(tb1[i]);
            req_b2_in[3*i +: 3] = 3'(tb2[i]);
            req_b3_in[4*i +: 4] = 4'(tb3[i]);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: brute-force residue decode, then plain compare.
    function automatic int decode(input int r1, input int r2, input int r3);
        for (int x = 0; x < 504; x++)
            if (x % 7 == r1 && x % 8 == r2 && x % 9 == r3) return x;
        return -1;
    endfunction

    function automatic int exp_res(input int i);
        int va, vb;
        if (ta1[i] > 6 || ta3[i] > 8 || tb1[i] > 6 || tb3[i] > 8) return 4'b1000;
        va = decode(ta1[i], ta2[i], ta3[i]);
        vb = decode(tb1[i], tb2[i], tb3[i]);
        if (va < vb)  return 4'b0001;
        if (va == vb) return 4'b0010;
        return 4'b0100;
    endfunction

    task automatic set_val(input int i, input int a, input int b);
        ta1[i] = a % 7; ta2[i] = a % 8; ta3[i] = a % 9;
        tb1[i] = b % 7; tb2[i] = b % 8; tb3[i] = b % 9;
    endtask

    int sb[$];
    int grant_log[$];
    int mptr = 0;
    int xfer_cnt = 0;

    // Monitor: sampled on the falling edge, between drive (posedge+1) and use.
    always @(negedge clk_in) begin
        int g, eg;
        if (!rst_n_in) begin
            mptr = 0;
        end else begin
            chk("ready_onehot", int'($countones(req_ready_out) <= 1), 1);
            g = -1;
            for (int i = 0; i < NREQ; i++)
                if (req_valid_in[i] && req_ready_out[i]) g = i;
            if (g >= 0) begin
                eg = -1;
                for (int k = NREQ - 1; k >= 0; k--)
                    if (req_valid_in[(mptr + k) % NREQ]) eg = (mptr + k) % NREQ;
                chk("grant_idx", g, eg);
                sb.push_back((g << 4) | exp_res(g));
                grant_log.push_back(g);
                mptr = (g + 1) % NREQ;
                xfer_cnt++;
            end
            if (resp_valid_out && resp_ready_in) begin
                if (sb.size() == 0)
                    chk("unexpected_resp", 1, 0);
                else
                    chk("resp", {26'd0, resp_id_out, resp_err_out, resp_gr_out,
                                 resp_eq_out, resp_le_out}, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Raise valid for requester i, hold until accepted, then drop it.
    task automatic send(input int i);
        int n;
        n = 0;
        req_valid_in[i] = 1'b1;
        @(negedge clk_in);
        while (!req_ready_out[i] && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        tick();
        req_valid_in[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_out) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle", int'(busy_out), 0);
    endtask

    task automatic pulse_reset();
        tick();
        rst_n_in = 1'b0;
        #1;
        sb.delete();
        grant_log.delete();
        tick();
        rst_n_in = 1'b1;
    endtask

    logic [5:0] snap;

    initial begin
        rst_n_in      = 1'b0;
        req_valid_in  = '0;
        resp_ready_in = 1'b1;
        for (int i = 0; i < NREQ; i++) set_val(i, 0, 0);
        #12;
        chk("rst_resp_valid", int'(resp_valid_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_flags", {resp_err_out, resp_gr_out, resp_eq_out, resp_le_out, resp_id_out}, 0);
        tick();
        rst_n_in = 1'b1;

        // Single request with latency check.
        set_val(0, 100, 200);
        send(0);
        chk("lat_before", int'(resp_valid_out), 0);
        tick();
        chk("lat_valid", int'(resp_valid_out), 1);
        drain();

        // Boundary values on requester 2.
        set_val(2, 503, 503); send(2);
        set_val(2, 0, 503);   send(2);
        set_val(2, 503, 0);   send(2);
        drain();

        // Out-of-range residues on requester 1.
        set_val(1, 10, 20); ta1[1] = 7; send(1);
        set_val(1, 10, 20); ta3[1] = 9; send(1);
        set_val(1, 10, 20); tb1[1] = 7; send(1);
        drain();

        // All requesters continuously valid from ptr=0.
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_val(i, 50 * i + 7, 300 - 40 * i);
        xfer_cnt = 0;
        req_valid_in = '1;
        repeat (5) tick();
        req_valid_in = '0;
        chk("rr_xfers", xfer_cnt, 5);
        chk("rr_len", grant_log.size(), 5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk("rr_order", grant_log[k], k % NREQ);
        drain();

        // Backpressure with both stages full.
        resp_ready_in = 1'b0;
        set_val(0, 11, 400); send(0);
        set_val(1, 450, 3);  send(1);
        tick();
        chk("bp_valid", int'(resp_valid_out), 1);
        snap = {resp_id_out, resp_err_out, resp_gr_out, resp_eq_out, resp_le_out};
        set_val(3, 5, 5);
        req_valid_in[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_ready_low", int'(req_ready_out), 0);
            chk("bp_hold", {26'd0, resp_id_out, resp_err_out, resp_gr_out,
                            resp_eq_out, resp_le_out}, int'(snap));
        end
        req_valid_in[3] = 1'b0;
        resp_ready_in = 1'b1;
        drain();

        // Reset with two results in flight.
        resp_ready_in = 1'b0;
        set_val(0, 1, 2); send(0);
        set_val(1, 3, 2); send(1);
        tick();
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_valid", int'(resp_valid_out), 0);
        chk("mid_rst_busy", int'(busy_out), 0);
        chk("mid_rst_ready", int'(req_ready_out), 0);
        sb.delete();
        grant_log.delete();
        tick();
        rst_n_in = 1'b1;
        resp_ready_in = 1'b1;
        set_val(2, 9, 9); set_val(3, 8, 9);
        req_valid_in = 4'b1100;
        tick();
        req_valid_in = '0;
        chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
